secret_buffer: RTL and testbench
================================

SECRET_BUFFER -- requirements
Module: secret_buffer

Interface
REQ-001 SHALL: parameter WORD_W, default 64, storage word width in bits (WORD_W/COEF_W secret coefficients per word).
REQ-002 SHALL: parameter COEF_W, default 4, secret coefficient width in bits; WORD_W SHALL be a multiple of COEF_W.
REQ-003 SHALL: parameter DEPTH, default 16, words per polynomial; power of two, at least 2.
REQ-004 SHALL: parameter NUM_POLY, default 3, polynomials held (vector length L).
REQ-005 SHALL: clk  input  1  single clock; all logic on its rising edge.
REQ-006 SHALL: rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL: clr  input  1  rewinds the write pointer and deasserts full.
REQ-008 SHALL: wr_en  input  1  write strobe for one load word.
REQ-009 SHALL: wr_data  input  WORD_W  load word.
REQ-010 SHALL: wr_ready  output  1  high when a write is accepted.
REQ-011 SHALL: full  output  1  high when all NUM_POLY*DEPTH words are loaded.
REQ-012 SHALL: rd_start  input  1  requests a burst read of one polynomial.
REQ-013 SHALL: rd_poly  input  clog2(NUM_POLY), minimum 1  polynomial index for rd_start.
REQ-014 SHALL: rd_hold  input  1  stalls the burst for one cycle per assertion.
REQ-015 SHALL: busy  output  1  burst in progress.
REQ-016 SHALL: rd_data  output  WORD_W  read word, registered.
REQ-017 SHALL: rd_valid  output  1  rd_data holds a new word this cycle.
REQ-018 SHALL: rd_last  output  1  coincides with rd_valid for the final word of a burst.

Function
REQ-019 SHALL: write accepted when wr_en and wr_ready; word stored at the write pointer, pointer increments by 1.
REQ-020 SHALL: wr_ready = !busy && !full; writes with wr_ready low are dropped without side effects.
REQ-021 SHALL: full asserts the cycle after the write to address NUM_POLY*DEPTH-1; the pointer wraps to 0 and holds until clr.
REQ-022 SHALL: clr has priority over a same-cycle write; pointer goes to 0, full to 0, the write is dropped, and memory contents are retained.
REQ-023 SHALL: FSM states are IDLE and READ; rd_start in IDLE with rd_poly < NUM_POLY latches base = rd_poly*DEPTH and moves to READ.
REQ-024 SHALL: rd_start while busy, or with rd_poly >= NUM_POLY, is ignored.
REQ-025 SHALL: in READ, each cycle with rd_hold low issues a read of base+offset and increments offset; a cycle with rd_hold high issues nothing.
REQ-026 SHALL: latency is 1 cycle: word issued in cycle N appears on rd_data with rd_valid high in cycle N+1.
REQ-027 SHALL: after DEPTH issues the FSM returns to IDLE; rd_last accompanies the word at offset DEPTH-1.
REQ-028 SHALL: busy is high from the cycle after an accepted rd_start through the rd_last cycle inclusive.
REQ-029 SHALL: rd_data holds its last value when rd_valid is low; rd_valid and rd_last are single-cycle pulses per word.
REQ-030 SHALL: a burst with no holds takes DEPTH+1 cycles from the accepted rd_start to rd_last.
REQ-031 SHALL: reads do not depend on full; unloaded words return the current memory contents.

Reset
REQ-032 SHALL: on rst, FSM goes to IDLE, write pointer and offset clear, and outputs are rd_data=0, rd_valid=0, rd_last=0, busy=0, full=0, wr_ready=1.
REQ-033 SHALL: rst mid-burst aborts the burst with no rd_last; memory contents are not reset.
REQ-034 SHALL: rst has priority over clr, wr_en and rd_start in the same cycle.

Structure
REQ-035 SHALL: WORD_W, COEF_W, DEPTH and NUM_POLY defaults and the FSM state enum live in the shared SABER parameters package.
REQ-036 SHALL: storage is one sub-module, secret_ram: simple dual-port, one write port and one registered read port, NUM_POLY*DEPTH x WORD_W, with no reset on the array.

Verification
REQ-037 SHALL: reset, then load 48 words with values 0..47 (defaults) -> full=1 the cycle after word 47; wr_ready=0.
REQ-038 SHALL: rd_start, rd_poly=1, no holds -> rd_valid on 16 consecutive cycles with data 16..31; rd_last with 31, 17 cycles after rd_start; busy falls after it.
REQ-039 SHALL: as REQ-038 with rd_hold high on cycles 3 and 7 of the burst -> same data order, two gaps, rd_last 19 cycles after rd_start.
REQ-040 SHALL: rd_poly=3 or rd_start mid-burst -> ignored; busy unchanged; no extra rd_valid.
REQ-041 SHALL: clr and wr_en in the same cycle when full -> pointer 0, full=0, memory unchanged; the next write lands at address 0.
REQ-042 SHALL: rst asserted at burst word 5 -> busy=0, rd_valid=0 next cycle, no rd_last; a re-read returns the preserved data.

Source files
------------

// File: rtl/secret_buffer_pkg.sv
// Shared SABER parameter defaults and types for the secret-coefficient buffer.
package secret_buffer_pkg;

    localparam int WORD_W_DEF   = 64;
    localparam int COEF_W_DEF   = 4;
    localparam int DEPTH_DEF    = 16;
    localparam int NUM_POLY_DEF = 3;

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } rd_state_e;

    // Polynomial-select width; a single polynomial still needs a 1-bit port.
    function automatic int poly_w(input int num_poly);
        return (num_poly > 1) ? $clog2(num_poly) : 1;
    endfunction

endpackage

// File: rtl/secret_buffer_if.sv
// Load and burst-read signal bundle for secret_buffer; master drives requests, slave answers.
interface secret_buffer_if
    import secret_buffer_pkg::*;
#(
    parameter int WORD_W   = WORD_W_DEF,
    parameter int NUM_POLY = NUM_POLY_DEF
) ();

    localparam int POLY_W = poly_w(NUM_POLY);

    logic              clr;
    logic              wr_en;
    logic [WORD_W-1:0] wr_data;
    logic              wr_ready;
    logic              full;
    logic              rd_start;
    logic [POLY_W-1:0] rd_poly;
    logic              rd_hold;
    logic              busy;
    logic [WORD_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_last;

    modport master (
        output clr, wr_en, wr_data, rd_start, rd_poly, rd_hold,
        input  wr_ready, full, busy, rd_data, rd_valid, rd_last
    );

    modport slave (
        input  clr, wr_en, wr_data, rd_start, rd_poly, rd_hold,
        output wr_ready, full, busy, rd_data, rd_valid, rd_last
    );

endinterface

// File: rtl/secret_ram.sv
// Simple dual-port storage: one write port, one registered read port.
module secret_ram #(
    parameter int WORD_W = 64,
    parameter int WORDS  = 48,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [WORDS];

    // NOTE: the array has no reset so it maps onto block RAM; contents survive rst.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Output register holds its value between reads so rd_data is stable when rd_valid is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/secret_buffer.sv
// Secret polynomial buffer: sequential word loading and per-polynomial burst reads.
module secret_buffer
    import secret_buffer_pkg::*;
#(
    parameter int WORD_W   = WORD_W_DEF,
    parameter int COEF_W   = COEF_W_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int NUM_POLY = NUM_POLY_DEF
) (
    input logic              clk,
    input logic              rst,
    secret_buffer_if.slave   bus
);

    localparam int WORDS  = NUM_POLY * DEPTH;
    localparam int ADDR_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int OFF_W  = $clog2(DEPTH);

    if (WORD_W % COEF_W != 0) begin : g_bad_coef_w
        $error("WORD_W must be a multiple of COEF_W");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of two, at least 2");
    end

    rd_state_e         state;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] rd_addr;
    logic [OFF_W-1:0]  offset;
    logic              full_q;
    logic              busy_q;
    logic              rd_valid_q;
    logic              rd_last_q;
    logic              wr_accept;
    logic              rd_accept;
    logic              issue;
    logic              last_issue;

    assign bus.wr_ready = !busy_q && !full_q;
    assign bus.full     = full_q;
    assign bus.busy     = busy_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_last  = rd_last_q;

    // clr wins over a same-cycle write, so the write is simply not accepted.
    assign wr_accept  = bus.wr_en && bus.wr_ready && !bus.clr;
    assign rd_accept  = bus.rd_start && (state == IDLE) && !busy_q
                        && (32'(bus.rd_poly) < 32'(NUM_POLY));
    assign issue      = (state == READ) && !bus.rd_hold;
    assign last_issue = issue && (offset == OFF_W'(DEPTH - 1));
    assign rd_addr    = base_q + ADDR_W'(offset);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            full_q <= 1'b0;
        end else if (bus.clr) begin
            wr_ptr <= '0;
            full_q <= 1'b0;
        end else if (wr_accept) begin
            if (wr_ptr == ADDR_W'(WORDS - 1)) begin
                wr_ptr <= '0;
                full_q <= 1'b1;
            end else begin
                wr_ptr <= wr_ptr + 1'b1;
            end
        end
    end

    // busy outlives the READ state by one cycle so it still covers the rd_last word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            base_q     <= '0;
            offset     <= '0;
            busy_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
        end else begin
            rd_valid_q <= issue;
            rd_last_q  <= last_issue;
            case (state)
                IDLE: begin
                    if (rd_accept) begin
                        state  <= READ;
                        base_q <= ADDR_W'(32'(bus.rd_poly) * 32'(DEPTH));
                        offset <= '0;
                        busy_q <= 1'b1;
                    end else if (rd_last_q) begin
                        busy_q <= 1'b0;
                    end
                end
                READ: begin
                    if (issue) begin
                        offset <= offset + 1'b1;
                        if (last_issue) begin
                            state <= IDLE;
                        end
                    end
                end
            endcase
        end
    end

    secret_ram #(
        .WORD_W (WORD_W),
        .WORDS  (WORDS),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_accept),
        .waddr (wr_ptr),
        .wdata (bus.wr_data),
        .re    (issue),
        .raddr (rd_addr),
        .rdata (bus.rd_data)
    );

endmodule

// File: tb/tb_secret_buffer.sv
// Directed bench for secret_buffer: expected burst words go into a scoreboard queue
// that an independent negedge monitor drains whenever rd_valid is seen.
module tb_secret_buffer;
    import secret_buffer_pkg::*;

    localparam int WW    = 64;
    localparam int DEPTH = 16;
    localparam int NP    = 3;

    typedef struct {
        logic [WW-1:0] data;
        logic          last;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    int   start_cyc;
    int   last_cyc;
    exp_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    secret_buffer_if #(.WORD_W(WW), .NUM_POLY(NP)) bus ();

    secret_buffer #(
        .WORD_W   (WW),
        .COEF_W   (4),
        .DEPTH    (DEPTH),
        .NUM_POLY (NP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [WW-1:0] d, input logic last);
        exp_t e;
        e.data = d;
        e.last = last;
        exp_q.push_back(e);
    endtask

    // Words first..first+n-1; the final one is flagged last only when is_full_burst.
    task automatic push_range(input int first, input int n, input logic is_full_burst);
        for (int j = 0; j < n; j++) begin
            push_word(WW'(first + j), is_full_burst && (j == n - 1));
        end
    endtask

    task automatic start_burst(input int p);
        bus.rd_start = 1'b1;
        bus.rd_poly  = 2'(p);
        start_cyc    = cyc;
        tick();
        bus.rd_start = 1'b0;
    endtask

    task automatic wait_last(output int at);
        logic found = 1'b0;
        at = -1;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (bus.rd_last === 1'b1) begin
                at    = cyc;
                found = 1'b1;
            end
        end
        check("rd_last seen", 64'(found), 64'd1);
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (bus.rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected rd_valid", 64'(bus.rd_valid), 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("rd_data", bus.rd_data, e.data);
                check("rd_last flag", 64'(bus.rd_last), 64'(e.last));
                check("busy with rd_valid", 64'(bus.busy), 64'd1);
            end
        end else if (bus.rd_last === 1'b1) begin
            check("rd_last without rd_valid", 64'(bus.rd_last), 64'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        bus.clr      = 1'b0;
        bus.wr_en    = 1'b0;
        bus.wr_data  = '0;
        bus.rd_start = 1'b0;
        bus.rd_poly  = '0;
        bus.rd_hold  = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("reset rd_data",  bus.rd_data, 64'd0);
        check("reset rd_valid", 64'(bus.rd_valid), 64'd0);
        check("reset rd_last",  64'(bus.rd_last), 64'd0);
        check("reset busy",     64'(bus.busy), 64'd0);
        check("reset full",     64'(bus.full), 64'd0);
        check("reset wr_ready", 64'(bus.wr_ready), 64'd1);

        // Load 0..47
        for (int i = 0; i < NP * DEPTH; i++) begin
            bus.wr_en   = 1'b1;
            bus.wr_data = WW'(i);
            if (i == NP * DEPTH - 1) begin
                @(negedge clk);
                check("full before last word", 64'(bus.full), 64'd0);
            end
            tick();
        end
        // Write attempt while full must be dropped (would otherwise hit address 0).
        bus.wr_data = 64'd99;
        @(negedge clk);
        check("full after word 47", 64'(bus.full), 64'd1);
        check("wr_ready when full", 64'(bus.wr_ready), 64'd0);
        tick();
        bus.wr_en = 1'b0;

        // Burst poly 1, no holds; a rd_start during the rd_last cycle is ignored.
        push_range(16, DEPTH, 1'b1);
        start_burst(1);
        wait_last(last_cyc);
        check("burst latency no holds", 64'(last_cyc - start_cyc), 64'd17);
        check("busy on rd_last cycle", 64'(bus.busy), 64'd1);
        bus.rd_start = 1'b1;
        bus.rd_poly  = 2'd0;
        tick();
        bus.rd_start = 1'b0;
        @(negedge clk);
        check("busy after rd_last", 64'(bus.busy), 64'd0);
        repeat (4) tick();

        // Burst poly 1 with holds on cycles 3 and 7, plus a mid-burst rd_start.
        push_range(16, DEPTH, 1'b1);
        start_burst(1);
        for (int c = 1; c <= 8; c++) begin
            bus.rd_hold  = (c == 3 || c == 7);
            bus.rd_start = (c == 5);
            bus.rd_poly  = 2'd0;
            tick();
        end
        bus.rd_hold  = 1'b0;
        bus.rd_start = 1'b0;
        @(negedge clk);
        check("busy after mid-burst rd_start", 64'(bus.busy), 64'd1);
        wait_last(last_cyc);
        check("burst latency two holds", 64'(last_cyc - start_cyc), 64'd19);
        repeat (4) tick();

        // Out-of-range polynomial is ignored.
        start_burst(3);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("busy after rd_poly=3", 64'(bus.busy), 64'd0);
        end
        tick();

        // Poly 0 intact: write while full was dropped.
        push_range(0, DEPTH, 1'b1);
        start_burst(0);
        wait_last(last_cyc);
        repeat (3) tick();

        // clr with same-cycle write while full.
        bus.clr     = 1'b1;
        bus.wr_en   = 1'b1;
        bus.wr_data = 64'hAA;
        tick();
        bus.clr   = 1'b0;
        bus.wr_en = 1'b0;
        @(negedge clk);
        check("full after clr",     64'(bus.full), 64'd0);
        check("wr_ready after clr", 64'(bus.wr_ready), 64'd1);
        tick();
        bus.wr_en   = 1'b1;
        bus.wr_data = 64'h1234;
        tick();
        bus.wr_en = 1'b0;

        // Read poly 0: new word at address 0, rest retained; writes during busy dropped.
        push_word(64'h1234, 1'b0);
        push_range(1, DEPTH - 1, 1'b1);
        start_burst(0);
        bus.wr_en   = 1'b1;
        bus.wr_data = 64'hBAD;
        @(negedge clk);
        check("wr_ready while busy", 64'(bus.wr_ready), 64'd0);
        wait_last(last_cyc);
        bus.wr_en = 1'b0;
        repeat (3) tick();

        // rst at burst word 5 of poly 2.
        push_range(32, 6, 1'b0);
        start_burst(2);
        repeat (6) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("busy after mid-burst rst",     64'(bus.busy), 64'd0);
        check("rd_valid after mid-burst rst", 64'(bus.rd_valid), 64'd0);
        check("rd_last after mid-burst rst",  64'(bus.rd_last), 64'd0);
        check("rd_data after mid-burst rst",  bus.rd_data, 64'd0);
        check("scoreboard after abort", 64'(exp_q.size()), 64'd0);
        tick();

        // Memory survives rst.
        push_range(32, DEPTH, 1'b1);
        start_burst(2);
        wait_last(last_cyc);
        check("re-read latency", 64'(last_cyc - start_cyc), 64'd17);
        repeat (3) tick();
        push_word(64'h1234, 1'b0);
        push_range(1, DEPTH - 1, 1'b1);
        start_burst(0);
        wait_last(last_cyc);
        repeat (4) tick();

        check("scoreboard drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
